nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port a, input, WIDTH bits: operand A.
REQ-005 SHALL have port b, input, WIDTH bits: operand B.
REQ-006 SHALL have port cin, input, 1 bit: carry-in to nibble 0.
REQ-007 SHALL have port in_valid, input, 1 bit: a, b and cin are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 SHALL have port sum, output, WIDTH bits: result, a+b+cin modulo 2^WIDTH.
REQ-010 SHALL have port cout, output, 1 bit: carry out of the MSB nibble.
REQ-011 SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_ready SHALL be a decode of the state.
REQ-015 SHALL accept operands on a clock edge where in_valid&&in_ready, capturing a, b and cin, clearing the nibble counter, and moving to RUN.
REQ-016 SHALL, on each RUN cycle, add nibble k of A and B plus the carry register with one 4-bit carry-select adder, shift the 4-bit result into the result register from the top, load the adder carry-out into the carry register, and increment k.
REQ-017 SHALL leave RUN for DONE on the edge that processes nibble WIDTH/4-1; at default WIDTH that is the 4th RUN edge after the accept edge.
REQ-018 SHALL assert out_valid only in DONE; out_valid SHALL first be high in the cycle after the final RUN edge.
REQ-019 SHALL hold sum and cout stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 SHALL, on an edge where out_valid&&out_ready, return to IDLE and keep sum and cout at their last values.
REQ-021 SHALL ignore in_valid while in RUN or DONE: no capture and no state change.
REQ-022 SHALL ignore operand changes after acceptance until the next accept.
REQ-023 SHALL give a minimum throughput of one add per WIDTH/4+2 cycles; DONE SHALL NOT accept new operands in the same cycle.
REQ-024 SHALL never assert cout or sum changes outside RUN and reset.

Reset
REQ-025 SHALL, when rst is asserted (asynchronously, at any state including mid-RUN), force state=IDLE, sum=0, cout=0, carry register=0, counter=0 and out_valid=0.
REQ-026 SHALL discard any in-flight operation on reset.
REQ-027 SHALL hold in_ready=1 during and after reset, because it decodes IDLE.
REQ-028 SHALL accept operands on the first clock edge after rst deasserts.

Structure
REQ-029 SHALL place the FSM state encoding and the NIB=4 constant in the shared package nsa_pkg.
REQ-030 SHALL instantiate exactly one existing 4-bit carry_select adder as its only sub-module.
REQ-031 SHALL keep the operand, result, carry and counter registers inside nibble_serial_adder.

Verification
REQ-032 SHALL cover: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid exactly 4 cycles after the accept edge, sum=0x5555, cout=0.
REQ-033 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, exercising the carry ripple through all nibbles.
REQ-034 SHALL cover: a=0xFFFF, b=0xFFFF, cin=1 with out_ready held 0 for 3 cycles -> sum=0xFFFF and cout=1 stable for all 3 cycles; IDLE reached after out_ready=1.
REQ-035 SHALL cover: in_valid held high during RUN with new operands -> the result equals the first operands only, and in_ready=0 throughout RUN and DONE.
REQ-036 SHALL cover: rst pulsed after the 2nd RUN edge -> out_valid=0, sum=0, cout=0 immediately; a following a=0x0001, b=0x0001, cin=1 gives sum=0x0003, cout=0.
REQ-037 SHALL cover: back-to-back transactions with out_ready=1 -> the 2nd accept edge occurs exactly 6 cycles after the 1st.

Source files
------------

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared FSM encoding and nibble width for the nibble-serial adder
package nsa_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

endpackage

// File: rtl/carry_select.sv
// rtl/carry_select.sv - 4-bit carry-select adder: 2-bit ripple low half, precomputed high half
module carry_select (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  always_comb begin
    lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    // Both high-half results exist before the low carry arrives; the carry only selects.
    hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    sum = lo[2] ? {hi1[1:0], lo[1:0]} : {hi0[1:0], lo[1:0]};
    cout = lo[2] ? hi1[2] : hi0[2];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder processing one nibble per cycle through one carry-select slice
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NNIB = WIDTH / NIB;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  nsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NIB-1:0]       nib_sum;
  logic                 nib_cout;
  logic [WIDTH+NIB-1:0] shifted;

  // Operand registers shift down each RUN cycle, so the current nibble is always at the bottom.
  carry_select u_cs (
    .a    (a_q[NIB-1:0]),
    .b    (b_q[NIB-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    shifted = {nib_sum, sum_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> NIB;
        b_d     = b_q >> NIB;
        sum_d   = shifted[WIDTH+NIB-1:NIB];
        carry_d = nib_cout;
        cnt_d   = cnt_q + 1'b1;
        // cout is published only with the final nibble so it never shows a partial carry.
        if (cnt_q == LAST) begin
          cout_d  = nib_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder with directed vectors
module tb_nibble_serial_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready = 1'b0;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every result handed over is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_sum", 32'(sum), 32'(e.s));
        check("sb_cout", 32'(cout), 32'(e.c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    sb.push_back('{s: es, c: ec});
    step();
    in_valid = 1'b0;
  endtask

  // hold: cycles out_ready stays low in DONE; noise: keep in_valid high with other operands.
  task automatic txn(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic cv, input logic [W-1:0] es, input logic ec,
                     input int hold, input bit noise);
    int lat;
    bit rdy_seen;
    out_ready = (hold == 0);
    accept(av, bv, cv, es, ec);
    if (noise) begin
      in_valid = 1'b1;
      a = 16'hAAAA;
      b = 16'h5555;
      cin = 1'b1;
    end
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_in_ready_run"}, 32'(rdy_seen), 32'd0);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(sum), 32'(es));
      check({tag, "_hold_cout"}, 32'(cout), 32'(ec));
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      if (i < hold - 1) step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, "_idle_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, accepts;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    txn("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b0);
    step();
    check("sum_kept_idle", 32'(sum), 32'h5555);
    check("cout_kept_idle", 32'(cout), 32'd0);

    txn("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
    txn("stall", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3, 1'b0);
    txn("ignore_in", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1, 1'b1);

    // Reset in the middle of RUN, then accept on the first edge after release.
    out_ready = 1'b1;
    accept(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    txn("post_rst", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 0, 1'b0);

    // Back-to-back with in_valid held high: measure the gap between accept edges.
    out_ready = 1'b1;
    a = 16'h0F0F;
    b = 16'h00F1;
    cin = 1'b0;
    in_valid = 1'b1;
    accepts = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 0; i < 30 && accepts < 2; i++) begin
      if (in_ready && in_valid) begin
        if (accepts == 0) begin
          sb.push_back('{s: 16'h1000, c: 1'b0});
        end else begin
          sb.push_back('{s: 16'h0000, c: 1'b1});
        end
        step();
        if (accepts == 0) begin
          t1 = cyc;
          a = 16'h8000;
          b = 16'h8000;
        end else begin
          t2 = cyc;
          in_valid = 1'b0;
        end
        accepts++;
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd2);
    check("b2b_gap", 32'(t2 - t1), 32'd6);
    for (int i = 0; i < 8; i++) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
